// File: rtl/booth_mul_ctrl_if.sv
// Issue-side handshake and operand/result bus of the Booth multiply controller.
interface booth_mul_ctrl_if;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic         busy;
  logic         op_done;
  logic [127:0] result;

  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output busy, op_done, result
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Radix-4 Booth 64x64 signed multiply, one digit/clock: op_done 33 cycles after start, start ignored while busy.
// BOOTH_EARLY_EXIT_EN: a zero operand skips EXEC and finishes one cycle after start.
module booth_enc (
  input  logic [7:0]  num_i,
  input  logic [64:0] q_ext_i,
  output logic [2:0]  b_operation_o,
  output logic [7:0]  next_num_o,
  output logic        s_interrupt_o
);
  logic [64:0] q_sh;
  logic [2:0]  trip;

  always_comb begin
    q_sh = q_ext_i >> (num_i - 8'd1);
    trip = q_sh[2:0];
    case (trip)
      3'b001, 3'b010: b_operation_o = 3'b001;
      3'b011:         b_operation_o = 3'b011;
      3'b100:         b_operation_o = 3'b100;
      3'b101, 3'b110: b_operation_o = 3'b010;
      default:        b_operation_o = 3'b000;
    endcase
    next_num_o    = num_i + 8'd2;
    s_interrupt_o = (num_i == 8'h3F);
  end
endmodule

module booth_mul_ctrl (
  input  logic              clk,
  input  logic              reset,
  booth_mul_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state_q;
  logic [63:0]  m_q;
  logic [64:0]  qext_q;
  logic [7:0]   num_q;
  logic [127:0] acc_q;
  logic [127:0] result_q;
  logic         busy_q;
  logic         done_q;

  logic [2:0]   b_op;
  logic [7:0]   next_num;
  logic         last_digit;
  logic [127:0] m_ext;
  logic [127:0] m2_ext;
  logic [127:0] pp_base;
  logic [127:0] pp;
  logic [127:0] acc_sum;
  logic         op_legal;

  booth_enc u_enc (
    .num_i         (num_q),
    .q_ext_i       (qext_q),
    .b_operation_o (b_op),
    .next_num_o    (next_num),
    .s_interrupt_o (last_digit)
  );

  // Negation is done at full 128-bit width so M = -2^63 needs no special case.
  always_comb begin
    m_ext    = {{64{m_q[63]}}, m_q};
    m2_ext   = m_ext << 1;
    op_legal = 1'b1;
    case (b_op)
      3'b000:  pp_base = '0;
      3'b001:  pp_base = m_ext;
      3'b010:  pp_base = -m_ext;
      3'b011:  pp_base = m2_ext;
      3'b100:  pp_base = -m2_ext;
      default: begin
        pp_base  = '0;
        op_legal = 1'b0;
      end
    endcase
    pp      = pp_base << (num_q - 8'd1);
    acc_sum = acc_q + pp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      qext_q   <= '0;
      num_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.op_clear) begin
      state_q  <= IDLE;
      num_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.op_start) begin
            m_q    <= bus.multiplicand;
            qext_q <= {bus.multiplier, 1'b0};
            num_q  <= 8'h01;
            acc_q  <= '0;
            busy_q <= 1'b1;
`ifdef BOOTH_EARLY_EXIT_EN
            if (bus.multiplicand == 64'd0 || bus.multiplier == 64'd0) begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= EXEC;
            end
`else
            state_q <= EXEC;
`endif
          end
        end
        EXEC: begin
          acc_q <= acc_sum;
          num_q <= next_num;
          if (last_digit) begin
            result_q <= acc_sum;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state_q == EXEC && !op_legal)
      $error("booth_mul_ctrl: illegal Booth code %b", b_op);
  end
`endif

  assign bus.busy    = busy_q;
  assign bus.op_done = done_q;
  assign bus.result  = result_q;
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed and randomized checks of booth_mul_ctrl: timing, signed corners, hold/clear/reset behaviour.
module tb_booth_mul_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  booth_mul_ctrl_if bus ();

  booth_mul_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Runs one operation from IDLE; j counts cycles after the accepting edge (j=1 is N+1).
  task automatic run_op(input logic [63:0] m, input logic [63:0] q,
                        output logic [127:0] res, output int done_at, output int busy_cnt);
    @(negedge clk);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.op_start     = 1'b1;
    done_at  = -1;
    busy_cnt = 0;
    res      = '0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      bus.op_start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.op_done && done_at < 0) begin
        done_at = j;
        res     = bus.result;
      end
      if (done_at > 0 && j == done_at + 1) break;
    end
  endtask

  task automatic test_reset;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.op_done); end
    n_vec++; if (bus.result !== 128'd0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.result); end
  endtask

  task automatic test_basic;
    logic [127:0] r; int d; int b;
    run_op(64'd3, 64'd5, r, d, b);
    n_vec++; if (r !== 128'd15) begin n_err++; $display("FAIL basic_result got %h want %h", r, 128'd15); end
    n_vec++; if (d !== 33) begin n_err++; $display("FAIL basic_done_cycle got %0d want 33", d); end
    n_vec++; if (b !== 33) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 33", b); end
  endtask

  task automatic test_signs;
    logic [127:0] r; int d; int b;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, d, b);
    n_vec++; if (r !== 128'd1) begin n_err++; $display("FAIL neg1_sq got %h want 1", r); end
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, d, b);
    n_vec++; if (r !== 128'h4000_0000_0000_0000_0000_0000_0000_0000) begin
      n_err++; $display("FAIL min_sq got %h want 4000..0", r); end
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'h7FFF_FFFF_FFFF_FFFF, r, d, b);
    n_vec++; if (r !== 128'hFFFF_FFFF_FFFF_FFFC_8000_0000_0000_0007) begin
      n_err++; $display("FAIL neg7_max got %h want fffffffffffffffc8000000000000007", r); end
  endtask

  task automatic test_hold_start;
    int done_at = -1; int done_cnt = 0; int busy_late = 0;
    logic [127:0] r = '0;
    @(negedge clk);
    bus.multiplicand = 64'd3;
    bus.multiplier   = 64'd5;
    bus.op_start     = 1'b1;
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.multiplicand = 64'd100;
        bus.multiplier   = 64'd100;
      end
      if (bus.op_done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = j; r = bus.result; end
      end
      if (j >= 34 && bus.busy) busy_late++;
      if (j == 33) bus.op_start = 1'b0;
    end
    n_vec++; if (r !== 128'd15) begin n_err++; $display("FAIL hold_result got %h want %h", r, 128'd15); end
    n_vec++; if (done_at !== 33) begin n_err++; $display("FAIL hold_done_cycle got %0d want 33", done_at); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL hold_done_count got %0d want 1", done_cnt); end
    n_vec++; if (busy_late !== 0) begin n_err++; $display("FAIL hold_no_requeue got %0d want 0", busy_late); end
  endtask

  task automatic test_clear;
    int done_cnt = 0;
    @(negedge clk);
    bus.multiplicand = 64'd2;
    bus.multiplier   = 64'd7;
    bus.op_start     = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL clear_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.result !== 128'd0) begin n_err++; $display("FAIL clear_result got %h want 0", bus.result); end
    for (int j = 0; j < 30; j++) begin
      if (bus.op_done) done_cnt++;
      @(negedge clk);
    end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL clear_no_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_clear_start;
    int busy_cnt = 0; int done_cnt = 0;
    @(negedge clk);
    bus.multiplicand = 64'd3;
    bus.multiplier   = 64'd5;
    bus.op_start     = 1'b1;
    bus.op_clear     = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    for (int j = 0; j < 35; j++) begin
      if (bus.busy) busy_cnt++;
      if (bus.op_done) done_cnt++;
      @(negedge clk);
    end
    n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL clrstart_busy got %0d want 0", busy_cnt); end
    n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL clrstart_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] r; int d; int b;
    run_op(64'd3, 64'd5, r, d, b);
    @(negedge clk);
    bus.multiplicand = 64'd5;
    bus.multiplier   = 64'd5;
    bus.op_start     = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", bus.op_done); end
    n_vec++; if (bus.result !== 128'd0) begin n_err++; $display("FAIL midrst_result got %h want 0", bus.result); end
    run_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFD, r, d, b);
    n_vec++; if (r !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA) begin
      n_err++; $display("FAIL after_rst_result got %h want ...fffa", r); end
  endtask

  task automatic test_zero;
    logic [127:0] r; int d; int b;
    int exp_d;
`ifdef BOOTH_EARLY_EXIT_EN
    exp_d = 1;
`else
    exp_d = 33;
`endif
    run_op(64'd0, 64'd5, r, d, b);
    n_vec++; if (r !== 128'd0) begin n_err++; $display("FAIL zero_result got %h want 0", r); end
    n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL zero_done_cycle got %0d want %0d", d, exp_d); end
  endtask

  task automatic test_random;
    logic [127:0] r; int d; int b;
    logic [63:0]  m, q;
    logic signed [127:0] ms, qs, e;
    for (int i = 0; i < 1000; i++) begin
      m = {$urandom, $urandom};
      q = {$urandom, $urandom};
      ms = {{64{m[63]}}, m};
      qs = {{64{q[63]}}, q};
      e  = ms * qs;
      run_op(m, q, r, d, b);
      n_vec++; if (r !== e) begin
        n_err++; $display("FAIL random_%0d m=%h q=%h got %h want %h", i, m, q, r, e); end
    end
  endtask

  initial begin
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_signs;
    test_hold_start;
    test_clear;
    test_clear_start;
    test_reset_mid;
    test_zero;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/booth_mul_ctrl.md
# booth_mul_ctrl

Sequential controller that drives the radix-4 Booth encoder (`booth_enc`) to compute a 64x64 signed product, one Booth digit per clock. Owns the operand registers, the 8-bit digit index, the 128-bit accumulator and the start/done handshake. Sits between the multiply-issue logic and the encoder/adder datapath of the Multiplier project.

## Interface

Parameters:
- none; widths fixed at 64-bit operands and 128-bit product.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; no other reset
- op_start  in  1  request; sampled only in IDLE
- op_clear  in  1  synchronous abort/clear; priority over op_start
- multiplicand  in  64  M, two's complement; captured on accepted op_start
- multiplier  in  64  Q, two's complement; captured on accepted op_start
- busy  out  1  high in EXEC and DONE
- op_done  out  1  one-cycle pulse, product valid
- result  out  128  signed product; held until next accepted op_start, clear or reset

## Operation

- States: IDLE, EXEC, DONE.
- IDLE: busy=0. On op_start=1 and op_clear=0: latch M; latch Q_ext = {Q, 1'b0} (65 bits); num=8'h01; acc=0; go to EXEC.
- EXEC: per cycle, the instantiated encoder receives num and Q_ext; it returns B_operation and next_num.
  - Decode: 3'b000 -> 0; 3'b001 -> +M; 3'b010 -> -M; 3'b011 -> +2M; 3'b100 -> -2M. Any other code -> treat as 0; flag in simulation.
  - pp = decoded value sign-extended to 128 bits, shifted left by (num-1).
  - acc <= acc + pp, modulo 2^128. num <= next_num.
  - When the encoder raises s_interrupt (num==8'h3F), this is the last digit: apply it, load result <= final acc, go to DONE.
- DONE: op_done=1 for exactly one cycle; busy=1; next state IDLE unconditionally.
- op_start in EXEC/DONE is ignored and never queued.
- op_clear in any state: next state IDLE; acc, num and result cleared to 0; op_done=0. op_clear and op_start in the same cycle: the clear wins and the start is dropped.
- Arithmetic: -M and -2M are formed as the 128-bit two's complement of the sign-extended M (or 2M). M = -2^63 must produce correct results; no overflow is possible in 128 bits.
- The 32 digits processed are num = 1, 3, ..., 63.

## Timing

- Reset values: busy=0, op_done=0, result=0, state IDLE, num=0, acc=0.
- op_start accepted at edge N -> EXEC during cycles N+1..N+32 -> DONE in cycle N+33 (op_done=1, result valid) -> IDLE in cycle N+34. A new op_start is accepted in N+34 at the earliest.
- result updates on the same edge that enters DONE and is stable from that cycle on.
- reset mid-operation: the operation is discarded and all outputs return to their reset values on the next edge.
- Encoder paths are combinational within one cycle; no multicycle paths.

## Configuration

- BOOTH_EARLY_EXIT_EN defined: in IDLE, an accepted op_start with multiplicand==0 or multiplier==0 goes directly to DONE with result=0. op_done follows in the next cycle (cycle N+1), and EXEC is skipped.
- Undefined: every operation takes the full 32 EXEC cycles, including zero operands (op_done at N+33, result=0).

## Test plan

- M=3, Q=5, op_start pulse -> op_done at exactly N+33, result=128'd15, busy high N+1..N+33.
- M=-1, Q=-1 -> result=1. Then M=64'h8000_0000_0000_0000 and Q=64'h8000_0000_0000_0000 -> result=128'h4000_0000_0000_0000_0000_0000_0000_0000.
- M=-7, Q=64'h7FFF_FFFF_FFFF_FFFF -> result = -7*(2^63-1) in 128-bit two's complement. Random signed pairs (>=1000) are compared against a behavioural `*` model.
- op_start held high through an operation with different operands -> only the first operation runs. Then op_clear at cycle N+10 -> IDLE next cycle, result=0, no op_done pulse.
- reset asserted at N+20 -> all outputs at reset values next cycle. A new op with M=2, Q=-3 started afterwards -> result=-6.
- M=0, Q=5: with BOOTH_EARLY_EXIT_EN, op_done at N+1 and result=0. Without the macro, op_done at N+33 and result=0.
